// File: rtl/htc_weight_stream_loader_if.sv
// AXI-Stream bundle carrying HV chunks and frame header
// from the PCIe DMA into the HTC weight loader.
interface htc_weight_stream_loader_if #(
  parameter int AXI_WIDTH = 64
);
  logic [AXI_WIDTH-1:0] tdata;
  logic                 tvalid;
  logic                 tlast;
  logic [31:0]          tuser;
  logic                 tready;

  modport master (
    output tdata, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/htc_weight_stream_loader.sv
// Reassembles bus-width chunks into HVs and writes them
// into bank-interleaved BRAM with framing/range checks.
module htc_weight_stream_loader #(
  parameter int D_PADDED  = 256,
  parameter int R         = 2048,
  parameter int AXI_WIDTH = 64,
  parameter int BANKS     = 4,
  localparam int CHUNKS   = D_PADDED / AXI_WIDTH,
  localparam int AW       = $clog2(R / BANKS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  htc_weight_stream_loader_if.slave s_axis,
  input  logic                 clear_stats,
  output logic [AW-1:0]        bram_addr,
  output logic [D_PADDED-1:0]  bram_wdata,
  output logic [BANKS-1:0]     bram_we,
  output logic                 busy,
  output logic [31:0]          hv_written,
  output logic                 frame_done,
  output logic                 frame_error,
  output logic [1:0]           err_code,
  output logic [63:0]          checksum
);

  localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int SLICES = D_PADDED / 64;
  localparam logic [16:0] R_LIM = 17'(R);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE, ACCUM, COMMIT, DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [15:0]         cur_id;
  logic [15:0]         hv_left;
  logic [CW-1:0]       chunk;
  logic [D_PADDED-1:0] hv_buf;
  logic [D_PADDED-1:0] hv_asm;
  logic                last_tl;

  logic [15:0] hdr_id, hdr_cnt, id_now;
  logic        hs, hdr_bad, left_one;
  logic        is_final, frame_end;
  logic        take_hdr, store, fin, early;
  logic        commit, err_pulse, done_arm;
  logic [1:0]  err_set;

  function automatic logic [63:0] fold(
    input logic [D_PADDED-1:0] v
  );
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < SLICES; i++)
      f ^= v[i*64 +: 64];
    return f;
  endfunction

  assign hdr_id  = s_axis.tuser[15:0];
  assign hdr_cnt = s_axis.tuser[31:16];
  assign s_axis.tready = (state_q != COMMIT);
  assign busy = (state_q != IDLE);
  assign hs = s_axis.tvalid && s_axis.tready;

  assign hdr_bad = (hdr_cnt == 16'd0) ||
    (({1'b0, hdr_id} + {1'b0, hdr_cnt}) > R_LIM);

  // In IDLE the header on the bus is the live frame context.
  assign id_now = (state_q == IDLE) ? hdr_id : cur_id;
  assign left_one = (state_q == IDLE) ?
    (hdr_cnt == 16'd1) : (hv_left == 16'd1);
  assign is_final  = (chunk == LAST_CHUNK);
  assign frame_end = is_final && left_one;

  always_comb begin
    hv_asm = hv_buf;
    hv_asm[chunk*AXI_WIDTH +: AXI_WIDTH] = s_axis.tdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    take_hdr  = 1'b0;
    store     = 1'b0;
    fin       = 1'b0;
    early     = 1'b0;
    commit    = 1'b0;
    err_pulse = 1'b0;
    done_arm  = 1'b0;
    err_set   = 2'd0;
    unique case (state_q)
      IDLE: if (hs) begin
        take_hdr = 1'b1;
        if (hdr_bad) begin
          err_set = 2'd1;
          if (s_axis.tlast) err_pulse = 1'b1;
          else              state_d = DRAIN;
        end else begin
          store = 1'b1;
        end
      end
      ACCUM: if (hs) store = 1'b1;
      COMMIT: begin
        commit = 1'b1;
        if (hv_left != 16'd1) begin
          state_d = ACCUM;
        end else if (last_tl) begin
          state_d = IDLE;
        end else begin
          err_set = 2'd3;
          state_d = DRAIN;
        end
      end
      DRAIN: if (hs && s_axis.tlast) begin
        err_pulse = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (store) begin
      if (s_axis.tlast && !frame_end) begin
        early     = 1'b1;
        err_set   = 2'd2;
        err_pulse = 1'b1;
        state_d   = IDLE;
      end else if (is_final) begin
        fin      = 1'b1;
        done_arm = s_axis.tlast;
        state_d  = COMMIT;
      end else begin
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_id      <= '0;
      hv_left     <= '0;
      chunk       <= '0;
      hv_buf      <= '0;
      last_tl     <= 1'b0;
      bram_addr   <= '0;
      bram_wdata  <= '0;
      bram_we     <= '0;
      hv_written  <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      err_code    <= 2'd0;
      checksum    <= '0;
    end else begin
      bram_we     <= '0;
      frame_done  <= done_arm;
      frame_error <= err_pulse;
      if (err_set != 2'd0) err_code <= err_set;
      if (take_hdr) begin
        cur_id  <= hdr_id;
        hv_left <= hdr_cnt;
      end
      if (store) begin
        hv_buf <= hv_asm;
        chunk  <= (is_final || early) ? '0 : chunk + 1'b1;
      end
      if (fin) begin
        bram_we    <= BANKS'(1) << (id_now % 16'(BANKS));
        bram_addr  <= AW'(id_now / 16'(BANKS));
        bram_wdata <= hv_asm;
        last_tl    <= s_axis.tlast;
      end
      // A clear coincident with a commit still counts that HV.
      if (commit) begin
        cur_id     <= cur_id + 16'd1;
        hv_left    <= hv_left - 16'd1;
        hv_written <= (clear_stats ? 32'd0 : hv_written) + 32'd1;
        checksum   <= (clear_stats ? 64'd0 : checksum) ^
                      fold(bram_wdata);
      end else if (clear_stats) begin
        hv_written <= '0;
        checksum   <= '0;
      end
    end
  end

endmodule

// File: doc/htc_weight_stream_loader.md
# htc_weight_stream_loader

Parametrised successor loader for HTC attractor weights. It accepts multi-beat, multi-HV burst frames over AXI-Stream from the PCIe DMA and reassembles hypervectors wider than the bus. Each HV is written into a bank-interleaved BRAM array. Frames are checked for range and framing errors, and the block keeps a running integrity checksum. It sits between the DMA stream and the HTC attractor memory banks.

## Interface
Parameters:
- `D_PADDED`, 256: stored HV width in bits; must be a multiple of 64 and of `AXI_WIDTH`.
- `R`, 2048: total attractors; must be a multiple of `BANKS`.
- `AXI_WIDTH`, 64: stream data width.
- `BANKS`, 4: BRAM bank count, power of 2.
- `CHUNKS` (derived) = `D_PADDED/AXI_WIDTH`.
- `AW` (derived) = `$clog2(R/BANKS)`.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in `AXI_WIDTH`: HV chunk data.
- `s_axis_tvalid` in 1: chunk valid.
- `s_axis_tlast` in 1: last beat of frame.
- `s_axis_tuser` in 32: frame header; `[15:0]`=start_id, `[31:16]`=count. Sampled on the first beat only.
- `s_axis_tready` out 1: loader accepts a beat.
- `clear_stats` in 1: zero `hv_written` and `checksum`.
- `bram_addr` out `AW`: row within bank.
- `bram_wdata` out `D_PADDED`: assembled HV.
- `bram_we` out `BANKS`: one-hot bank write enable.
- `busy` out 1: state ≠ IDLE.
- `hv_written` out 32: count of committed HVs.
- `frame_done` out 1: 1-cycle pulse, frame completed cleanly.
- `frame_error` out 1: 1-cycle pulse, frame terminated with error.
- `err_code` out 2: code of the last error; holds until the next error. 1=range, 2=early tlast, 3=missing tlast.
- `checksum` out 64: running XOR of all 64-bit slices of committed HVs.

## Operation
- Frame = count×CHUNKS beats. Chunk k of an HV lands in bits `[k*AXI_WIDTH +: AXI_WIDTH]`, chunk 0 first.
- Attractor id `a` maps to bank `a % BANKS` and row `a / BANKS`.
- States:
  - IDLE: first beat accepted. Header latched; cur_id=start_id; beats_left=count.
    - If count=0 or start_id+count>R: err_code=1. Go to DRAIN, or pulse `frame_error` and stay in IDLE if this beat has tlast.
    - Otherwise store chunk 0. If CHUNKS=1, go to COMMIT; else go to ACCUM.
  - ACCUM: store chunks 1..CHUNKS-1.
    - tlast on a non-final beat of the frame: discard the partial HV, err_code=2, pulse `frame_error`, go to IDLE.
    - Final chunk of an HV: go to COMMIT.
  - COMMIT (1 cycle, tready=0): `bram_we`/`addr`/`wdata` asserted; `hv_written`++; `checksum` ^= slices; cur_id++.
    - Last HV of frame and its final beat had tlast: pulse `frame_done` in the same cycle, go to IDLE.
    - Last HV but tlast was absent: err_code=3, go to DRAIN.
    - Otherwise go to ACCUM.
  - DRAIN: accept and discard beats until tlast. On the tlast handshake, pulse `frame_error` and go to IDLE.
- HVs committed before an error remain written. There is no rollback.
- `s_axis_tready` = state ∈ {IDLE, ACCUM, DRAIN}.
- `clear_stats` coincident with a commit: counters zeroed, then that commit applied (`hv_written`=1, `checksum`=that HV's fold).
- `hv_written` wraps modulo 2^32.

## Timing
- Reset values: `s_axis_tready`=1 (IDLE), `bram_we`=0, `bram_addr`=0, `bram_wdata`=0, `busy`=0, `hv_written`=0, `frame_done`=0, `frame_error`=0, `err_code`=0, `checksum`=0.
- All outputs are registered except `s_axis_tready` and `busy`, which decode directly from state.
- `bram_we` is high for exactly the one cycle after the final chunk handshake of an HV.
- `checksum` and `hv_written` reflect that HV in the following cycle.
- Throughput: CHUNKS+1 cycles per HV with tvalid held high. tvalid gaps only stretch the accept states.
- Reset mid-frame: returns to IDLE immediately and no partial write is issued. The upstream stream must be reset as well.

## Test plan
Defaults apply: CHUNKS=4, BANKS=4.
- **Single HV:** header id=5, count=1; beats b0..b3, tlast on b3.
  - Expect `bram_we`=4'b0010, `addr`=1, `wdata`={b3,b2,b1,b0}.
  - Expect `frame_done` coincident with the write and `hv_written`=1.
  - Expect 5 cycles from the first beat to the write.
- **Bank boundary burst:** id=2046, count=2.
  - Expect writes (bank2, row 511) then (bank3, row 511), `frame_done` once.
  - Then id=2047, count=2: all 8 beats drained, no write, `frame_error`, `err_code`=1.
- **Early tlast:** count=3, tlast on beat 6 (chunk 1 of HV1).
  - Expect HV0 written, HV1 discarded, `err_code`=2, `hv_written` up by 1, back in IDLE.
- **Missing tlast:** count=1, 6 beats with tlast on beat 6.
  - Expect HV written after beat 4, beats 5–6 drained, `frame_error` after beat 6, `err_code`=3.
- **Checksum with backpressure:** random tvalid gaps.
  - Write an all-ones HV: expect `checksum`=0.
  - Then write an HV with slice0=0x1 and other slices 0: expect `checksum`=0x1.
  - Pulse `clear_stats` during that write: expect `hv_written`=1, `checksum`=0x1.
- **Reset mid-frame:** assert `rst_n`=0 after beat 2 of a count=2 frame.
  - Expect every output at its reset value and no `bram_we`.
  - A fresh frame afterwards loads normally.
